// File: rtl/hsp_fifo_param.sv
// hsp_fifo_param: first-word-fall-through FIFO of HSP records (s, q, l, score)
// with valid/ready handshakes, occupancy count, almost-full and drop counter.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready = !full
//   in_s/in_q/in_l/in_score  input record; in_l==0 marks a null record
//   min_score            score threshold (HSP_FIFO_SCORE_FILTER_EN only)
//   out_valid/out_ready  output handshake; out_valid = !empty
//   out_s/out_q/out_l/out_score  head record, zero when empty
//   count, empty, full, afull    occupancy and flags from registered count
//   drop_cnt             saturating count of accepted-but-discarded records
//
// Build option: define HSP_FIFO_SCORE_FILTER_EN to also discard accepted
// records whose score is below min_score.

module hsp_fifo_param #(
   parameter int S_W          = 8,
   parameter int Q_W          = 8,
   parameter int L_W          = 8,
   parameter int SCORE_W      = 8,
   parameter int DEPTH_LOG2   = 8,
   parameter int AFULL_THRESH = 2**DEPTH_LOG2-4,
   parameter int DROP_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [S_W-1:0]        in_s,
   input  logic [Q_W-1:0]        in_q,
   input  logic [L_W-1:0]        in_l,
   input  logic [SCORE_W-1:0]    in_score,
   input  logic [SCORE_W-1:0]    min_score,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [S_W-1:0]        out_s,
   output logic [Q_W-1:0]        out_q,
   output logic [L_W-1:0]        out_l,
   output logic [SCORE_W-1:0]    out_score,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  afull,
   output logic [DROP_W-1:0]     drop_cnt
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int REC_W = S_W + Q_W + L_W + SCORE_W;
   localparam int PTR_W = DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

   // A negative threshold clamps to zero: afull is then always set.
   localparam logic [31:0] AFULL_U =
      (AFULL_THRESH < 0) ? 32'd0 : 32'(AFULL_THRESH);

   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic              accept;
   logic              keep;
   logic              push;
   logic              pop;
   logic              drop;
   logic              score_ok;
   logic [REC_W-1:0]  head;

`ifdef HSP_FIFO_SCORE_FILTER_EN
   assign score_ok = (in_score >= min_score);
`else
   logic unused_min_score;
   assign unused_min_score = ^min_score;
   assign score_ok = 1'b1;
`endif

   // Flags come only from the registered count.
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_FULL);
   assign afull     = (32'(count_q) >= AFULL_U);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign count     = count_q;
   assign drop_cnt  = drop_q;

   // No write-through when full: accept ignores a same-cycle pop.
   assign accept = in_valid && !full;
   assign keep   = (in_l != '0) && score_ok;
   assign push   = accept && keep;
   assign drop   = accept && !keep;
   assign pop    = out_valid && out_ready;

   assign head = mem_q[rd_ptr_q];

   always_comb begin
      out_s     = '0;
      out_q     = '0;
      out_l     = '0;
      out_score = '0;
      if (out_valid) begin
         {out_s, out_q, out_l, out_score} = head;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (drop && (drop_q != '1)) begin
         drop_d = drop_q + DROP_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_s, in_q, in_l, in_score};
      end
   end

endmodule

// File: tb/tb_hsp_fifo_param.sv
// tb_hsp_fifo_param: directed table, corner sequences and random traffic
// for hsp_fifo_param (depth 4, afull at 3, 2-bit drop counter).

module tb_hsp_fifo_param;

   localparam int DEPTH = 4;
   localparam int AFT   = 3;
   localparam int DMAX  = 3;

   typedef struct packed {
      logic [7:0] s;
      logic [7:0] q;
      logic [7:0] l;
      logic [7:0] sc;
   } rec_t;

   typedef struct {
      logic v;
      rec_t r;
      logic rdy;
      int   ecnt;
      logic eov;
      rec_t eout;
      int   edrop;
      logic efull;
      logic eafull;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_s, in_q, in_l, in_score, min_score;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_s, out_q, out_l, out_score;
   logic [2:0] count;
   logic       empty, full, afull;
   logic [1:0] drop_cnt;

   int checks = 0;
   int errors = 0;

   rec_t mq[$];
   int   mdrop;

   always #5 clk = ~clk;

   hsp_fifo_param #(
      .S_W(8), .Q_W(8), .L_W(8), .SCORE_W(8),
      .DEPTH_LOG2(2), .AFULL_THRESH(AFT), .DROP_W(2)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_s(in_s), .in_q(in_q), .in_l(in_l),
      .in_score(in_score), .min_score(min_score),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_q(out_q), .out_l(out_l),
      .out_score(out_score),
      .count(count), .empty(empty), .full(full),
      .afull(afull), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic kept(input rec_t r);
`ifdef HSP_FIFO_SCORE_FILTER_EN
      return (r.l != 0) && (r.sc >= min_score);
`else
      return (r.l != 0);
`endif
   endfunction

   // Reference: a queue with a capacity, applied on the pre-edge state.
   task automatic model_step(input logic v, input rec_t r, input logic rdy);
      logic acc, pp;
      acc = v && (mq.size() < DEPTH);
      pp  = rdy && (mq.size() > 0);
      if (pp) void'(mq.pop_front());
      if (acc) begin
         if (kept(r)) mq.push_back(r);
         else if (mdrop < DMAX) mdrop++;
      end
   endtask

   task automatic check_all();
      rec_t h;
      int   n;
      n = mq.size();
      h = (n > 0) ? mq[0] : '0;
      chk("count", 32'(count), 32'(n));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("afull", 32'(afull), 32'(n >= AFT));
      chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(n > 0));
      chk("out_rec", {out_s, out_q, out_l, out_score}, h);
      chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
   endtask

   // Called just after a negedge; returns just after the next negedge.
   task automatic cyc(input logic v, input rec_t r, input logic rdy);
      in_valid  = v;
      in_s      = r.s;
      in_q      = r.q;
      in_l      = r.l;
      in_score  = r.sc;
      out_ready = rdy;
      @(posedge clk);
      model_step(v, r, rdy);
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      mdrop = 0;
      check_all();
   endtask

   function automatic rec_t mk(input int s, input int q,
                               input int l, input int sc);
      rec_t r;
      r.s  = 8'(s);
      r.q  = 8'(q);
      r.l  = 8'(l);
      r.sc = 8'(sc);
      return r;
   endfunction

   vec_t tbl[17];
   rec_t z;
   rec_t nl;
   rec_t r;

   initial begin
      z  = '0;
      nl = mk(9, 9, 0, 9);
      tbl[0]  = '{1, mk(3,5,7,20),   0, 1, 1, mk(3,5,7,20),   0, 0, 0};
      tbl[1]  = '{0, z,              1, 0, 0, z,              0, 0, 0};
      tbl[2]  = '{1, mk(1,11,1,30),  0, 1, 1, mk(1,11,1,30),  0, 0, 0};
      tbl[3]  = '{1, mk(2,12,2,31),  0, 2, 1, mk(1,11,1,30),  0, 0, 0};
      tbl[4]  = '{1, mk(3,13,3,32),  0, 3, 1, mk(1,11,1,30),  0, 0, 1};
      tbl[5]  = '{1, mk(4,14,4,33),  0, 4, 1, mk(1,11,1,30),  0, 1, 1};
      tbl[6]  = '{1, mk(5,15,5,34),  0, 4, 1, mk(1,11,1,30),  0, 1, 1};
      tbl[7]  = '{1, mk(5,15,5,34),  1, 3, 1, mk(2,12,2,31),  0, 0, 1};
      tbl[8]  = '{0, z,              1, 2, 1, mk(3,13,3,32),  0, 0, 0};
      tbl[9]  = '{1, nl,             1, 1, 1, mk(4,14,4,33),  1, 0, 0};
      tbl[10] = '{1, mk(6,16,6,35),  0, 2, 1, mk(4,14,4,33),  1, 0, 0};
      tbl[11] = '{0, z,              1, 1, 1, mk(6,16,6,35),  1, 0, 0};
      tbl[12] = '{1, nl,             1, 0, 0, z,              2, 0, 0};
      tbl[13] = '{1, nl,             0, 0, 0, z,              3, 0, 0};
      tbl[14] = '{1, nl,             0, 0, 0, z,              3, 0, 0};
      tbl[15] = '{1, nl,             0, 0, 0, z,              3, 0, 0};
      tbl[16] = '{1, mk(7,17,7,36),  1, 1, 1, mk(7,17,7,36),  3, 0, 0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_s      = '0;
      in_q      = '0;
      in_l      = '0;
      in_score  = '0;
      min_score = 8'd10;
      out_ready = 1'b0;
      mdrop     = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      check_all();

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].v, tbl[i].r, tbl[i].rdy);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
         chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].eov));
         chk($sformatf("tbl%0d_out", i),
             {out_s, out_q, out_l, out_score}, tbl[i].eout);
         chk($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].edrop));
         chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].efull));
         chk($sformatf("tbl%0d_afull", i), 32'(afull), 32'(tbl[i].eafull));
      end

      // Full with in_valid and out_ready held: ordering across wrap.
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, mk(k, k+1, 1, 50), 0);
      chk("wrap_full", 32'(full), 1);
      for (int k = 4; k < 14; k++) begin
         cyc(1, mk(k, k+1, 1, 50), 1);
         chk("wrap_count_range", 32'(count >= 3), 1);
      end
      for (int i = 0; i < 8 && mq.size() > 0; i++) cyc(0, z, 1);
      chk("wrap_drained", 32'(empty), 1);

      // Score filter: scores 9, 10, 11 against min_score 10.
      do_reset();
      min_score = 8'd10;
      cyc(1, mk(1, 1, 1, 9), 0);
      cyc(1, mk(2, 2, 2, 10), 0);
      cyc(1, mk(3, 3, 3, 11), 0);
`ifdef HSP_FIFO_SCORE_FILTER_EN
      chk("filt_count", 32'(count), 2);
      chk("filt_drop", 32'(drop_cnt), 1);
      chk("filt_head", 32'(out_score), 10);
`else
      chk("filt_count", 32'(count), 3);
      chk("filt_drop", 32'(drop_cnt), 0);
      chk("filt_head", 32'(out_score), 9);
`endif
      for (int i = 0; i < 8 && mq.size() > 0; i++) cyc(0, z, 1);

      // Reset mid-stream with two records held.
      do_reset();
      cyc(1, mk(1, 2, 3, 40), 0);
      cyc(1, mk(4, 5, 6, 41), 0);
      chk("mid_count2", 32'(count), 2);
      #2 rst = 1'b1;
      #1;
      chk("mid_ov", 32'(out_valid), 0);
      chk("mid_count", 32'(count), 0);
      chk("mid_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      mq.delete();
      mdrop = 0;
      check_all();
      cyc(1, mk(8'hAA, 1, 1, 42), 0);
      cyc(1, mk(8'hBB, 2, 2, 43), 0);
      chk("mid_first", 32'(out_s), 32'h00AA);
      cyc(0, z, 1);
      chk("mid_second", 32'(out_s), 32'h00BB);

      // Random traffic against the queue model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r.s  = 8'($urandom);
         r.q  = 8'($urandom);
         r.l  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
         r.sc = 8'($urandom_range(0, 63));
         min_score = 8'($urandom_range(0, 40));
         if (i % 100 == 50) begin
            mq.delete();
            mdrop = 0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         cyc(($urandom_range(0, 3) != 0),
             r,
             ($urandom_range(0, 9) < ((i / 50) % 2 ? 8 : 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
